corr_sequencer: RTL and testbench
=================================

Name: corr_sequencer

Overview:
- Control stage directly upstream of the correlator MAC.
- Walks the sample dual-port RAM (x, circular history) and the coefficient RAM (y) for one correlation lag.
- Drives the MAC clear/enable/request strobes aligned to the 1-cycle RAM read latency, waits for the MAC's done, then reports completion with a status flag.
- One start pulse produces one 40-bit accumulation, which the downstream shifter turns into a 16-bit audio word.

Parameters:
- ADDR, 8, RAM address width; tap count up to 2**ADDR.
- TIMEOUT, 64, maximum cycles to wait for mac_done before aborting.

Ports:
- ck  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to run a correlation; ignored unless idle.
- offset  in  ADDR  lag/base address into x RAM, sampled on accepted start.
- length  in  ADDR+1  number of taps N, 0..2**ADDR, sampled on accepted start.
- re  out  1  read enable to both RAMs.
- raddr_x  out  ADDR  x RAM read address.
- raddr_y  out  ADDR  y RAM read address.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate x*y presented this cycle.
- mac_req  out  1  marks the final product of the run.
- mac_done  in  1  MAC result valid (one-cycle pulse).
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  valid with done: 1 if MAC never answered.

Behaviour:
- All outputs are registered. Reset value of every output is 0; state goes to IDLE.
- Reset asserted mid-run aborts the run: next cycle all outputs are 0, with no done pulse.
- Edge numbering: edge 0 is the edge at which start is sampled high in IDLE. Offset and length latch at edge 0.
- States: IDLE -> CLEAR -> FETCH -> DRAIN -> WAIT -> FIN -> IDLE.
- After edge 1 (CLEAR):
  - mac_clr=1, busy=1.
  - If N>0: re=1, raddr_x=offset, raddr_y=0.
- After edge 1+i, for i=0..N-1 (FETCH):
  - re=1, raddr_y=i.
  - raddr_x=(offset+i) mod 2**ADDR, wrapping past the top with no stall.
- mac_clr=1 after edge 1 only.
- mac_en=1 after edges 2..N+1. This is re delayed one cycle, matching RAM latency.
- mac_req=1 after edge N+1 only, coincident with the last mac_en.
- re=0 from edge N+1. DRAIN lasts one cycle.
- WAIT: counts cycles from edge N+2.
  - mac_done sampled high -> FIN with timeout=0.
  - Counter reaching TIMEOUT -> FIN with timeout=1.
  - mac_done arriving in the same cycle as the counter reaching TIMEOUT is treated as success.
- FIN (one cycle): done=1, busy=0 at the same edge. The next start is accepted on the following edge.
- N=0: CLEAR (mac_clr=1, re=0), then straight to FIN. done pulses after edge 2 with timeout=0; no mac_en or mac_req.
- N=1: mac_en and mac_req are both high after edge 2 only.
- N=2**ADDR: every address is visited exactly once; raddr_y ends at 2**ADDR-1.
- start while busy or during FIN: ignored, not queued.
- mac_done outside WAIT: ignored.

Decomposition:
- Package corr_pkg:
  - State enum (IDLE, CLEAR, FETCH, DRAIN, WAIT, FIN).
  - ADDR default.
  - Accumulator width constant 40 and sample width 16, shared with the MAC and shifter.
- No sub-module. The tap counter and timeout counter are small enough to stay inline.

Test Plan:
- Basic run: reset 3 cycles; start with offset=0, N=5; MAC model returns done 2 cycles after mac_req.
  - mac_clr after edge 1; mac_en after edges 2-6; mac_req after edge 6 only.
  - raddr_x=raddr_y=0..4; done and busy fall at the edge after mac_done; timeout=0.
- Wrap: offset=254, N=4 -> raddr_x sequence 254, 255, 0, 1 and raddr_y 0..3. With x RAM = index and y=16'h7fff, the MAC reference sum matches.
- Edge lengths:
  - N=0 -> done after edge 2, no mac_en or mac_req.
  - N=1 -> a single cycle with mac_en and mac_req together.
  - N=256 -> 256 mac_en cycles.
- Timeout: mac_done held low -> done with timeout=1 exactly TIMEOUT cycles after WAIT entry; busy=0 afterwards.
- Start while busy: pulse start at edge 3 of an N=5 run -> no effect on addresses or length, exactly one done.
- Reset mid-run: assert reset after edge 4 -> next cycle all outputs 0, no done. A new start afterwards runs a clean N=5 sequence.

Source files
------------

// File: rtl/corr_pkg.sv
`default_nettype none
// ============================================================================
//  corr_pkg
//  Shared types and constants for the correlator control/MAC/shifter chain.
//  Revision: 1.0
// ============================================================================
package corr_pkg;

    localparam int ADDR_DEFAULT    = 8;
    localparam int TIMEOUT_DEFAULT = 64;
    localparam int ACC_W           = 40;
    localparam int SAMPLE_W        = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        WAIT  = 3'd4,
        FIN   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/corr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  corr_sequencer_if
//  Request, RAM-read and MAC-strobe bundle of the correlation sequencer.
//  Revision: 1.0
// ============================================================================
interface corr_sequencer_if #(
    parameter int ADDR = corr_pkg::ADDR_DEFAULT
);
    logic            start;
    logic [ADDR-1:0] offset;
    logic [ADDR:0]   length;
    logic            re;
    logic [ADDR-1:0] raddr_x;
    logic [ADDR-1:0] raddr_y;
    logic            mac_clr;
    logic            mac_en;
    logic            mac_req;
    logic            mac_done;
    logic            busy;
    logic            done;
    logic            timeout;

    // Sequencer side
    modport master (
        input  start, offset, length, mac_done,
        output re, raddr_x, raddr_y, mac_clr, mac_en, mac_req, busy, done, timeout
    );

    // Requester / RAM / MAC side
    modport slave (
        output start, offset, length, mac_done,
        input  re, raddr_x, raddr_y, mac_clr, mac_en, mac_req, busy, done, timeout
    );
endinterface
`default_nettype wire

// File: rtl/corr_sequencer.sv
`default_nettype none
// ============================================================================
//  corr_sequencer
//  Walks x (circular) and y RAMs for one lag, strobes the MAC, reports status.
//  Revision: 1.0
// ============================================================================
module corr_sequencer
    import corr_pkg::*;
#(
    parameter int ADDR    = ADDR_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  wire logic         ck,
    input  wire logic         reset,
    corr_sequencer_if.master  bus
);

    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

    state_t              r_state,   w_state_nxt;
    logic [ADDR-1:0]     r_offset,  w_offset_nxt;
    logic [ADDR:0]       r_len,     w_len_nxt;
    logic [ADDR:0]       r_idx,     w_idx_nxt;
    logic [c_WAIT_W-1:0] r_wait,    w_wait_nxt;
    logic                r_fail,    w_fail_nxt;

    logic                r_re,      w_re_nxt;
    logic [ADDR-1:0]     r_raddr_x, w_raddr_x_nxt;
    logic [ADDR-1:0]     r_raddr_y, w_raddr_y_nxt;
    logic                r_clr,     w_clr_nxt;
    logic                r_en,      w_en_nxt;
    logic                r_req,     w_req_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_tmo,     w_tmo_nxt;

    always_ff @(posedge ck) begin
        if (reset) begin
            r_state   <= IDLE;
            r_offset  <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_wait    <= '0;
            r_fail    <= 1'b0;
            r_re      <= 1'b0;
            r_raddr_x <= '0;
            r_raddr_y <= '0;
            r_clr     <= 1'b0;
            r_en      <= 1'b0;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_offset  <= w_offset_nxt;
            r_len     <= w_len_nxt;
            r_idx     <= w_idx_nxt;
            r_wait    <= w_wait_nxt;
            r_fail    <= w_fail_nxt;
            r_re      <= w_re_nxt;
            r_raddr_x <= w_raddr_x_nxt;
            r_raddr_y <= w_raddr_y_nxt;
            r_clr     <= w_clr_nxt;
            r_en      <= w_en_nxt;
            r_req     <= w_req_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_tmo     <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_offset_nxt  = r_offset;
        w_len_nxt     = r_len;
        w_idx_nxt     = r_idx;
        w_wait_nxt    = r_wait;
        w_fail_nxt    = r_fail;
        w_re_nxt      = 1'b0;
        w_raddr_x_nxt = r_raddr_x;
        w_raddr_y_nxt = r_raddr_y;
        w_clr_nxt     = 1'b0;
        // The RAM answers one cycle after re, so mac_en is simply re delayed.
        w_en_nxt      = r_re;
        w_req_nxt     = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_tmo_nxt     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_offset_nxt = bus.offset;
                    w_len_nxt    = bus.length;
                    w_state_nxt  = CLEAR;
                end
            end
            CLEAR: begin
                w_clr_nxt  = 1'b1;
                w_busy_nxt = 1'b1;
                w_fail_nxt = 1'b0;
                if (r_len != '0) begin
                    w_re_nxt      = 1'b1;
                    w_raddr_x_nxt = r_offset;
                    w_raddr_y_nxt = '0;
                    w_idx_nxt     = (ADDR+1)'(1);
                    w_state_nxt   = FETCH;
                end else begin
                    w_state_nxt   = FIN;
                end
            end
            FETCH: begin
                if (r_idx == r_len) begin
                    // Last product is entering the MAC this cycle.
                    w_req_nxt   = 1'b1;
                    w_state_nxt = DRAIN;
                end else begin
                    w_re_nxt      = 1'b1;
                    w_raddr_x_nxt = r_offset + r_idx[ADDR-1:0];
                    w_raddr_y_nxt = r_idx[ADDR-1:0];
                    w_idx_nxt     = r_idx + (ADDR+1)'(1);
                end
            end
            DRAIN: begin
                w_wait_nxt  = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // mac_done wins over an expiring counter in the same cycle.
                if (bus.mac_done) begin
                    w_fail_nxt  = 1'b0;
                    w_state_nxt = FIN;
                end else if (r_wait == c_WAIT_W'(TIMEOUT - 1)) begin
                    w_fail_nxt  = 1'b1;
                    w_state_nxt = FIN;
                end else begin
                    w_wait_nxt  = r_wait + c_WAIT_W'(1);
                end
            end
            FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_tmo_nxt   = r_fail;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.re      = r_re;
    assign bus.raddr_x = r_raddr_x;
    assign bus.raddr_y = r_raddr_y;
    assign bus.mac_clr = r_clr;
    assign bus.mac_en  = r_en;
    assign bus.mac_req = r_req;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.timeout = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_corr_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_corr_sequencer
//  Randomized runs against a cycle-indexed reference of the sequencer rules.
//  Revision: 1.0
// ============================================================================
module tb_corr_sequencer;
    import corr_pkg::*;

    localparam int A     = 8;
    localparam int DEPTH = 1 << A;
    localparam int TMO   = 64;
    localparam longint YV = (longint'(1) << (SAMPLE_W - 1)) - 1;

    logic ck    = 1'b0;
    logic reset = 1'b1;
    always #5 ck = ~ck;

    corr_sequencer_if #(.ADDR(A)) bus();

    corr_sequencer #(.ADDR(A), .TIMEOUT(TMO)) dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint ref_sum(input int off, input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'((off + i) % DEPTH) * YV;
        return s;
    endfunction

    // Reference: outputs after edge t of a run follow directly from N, offset
    // and the edge at which the MAC answered inside the WAIT window.
    bit m_active = 1'b0;
    int m_t = 0, m_n = 0, m_off = 0, m_tfin = 0;
    bit m_to = 1'b0;
    bit e_re, e_clr, e_en, e_req, e_busy, e_done, e_to;
    int e_ax, e_ay;

    always @(posedge ck) begin
        if (reset) begin
            m_active = 1'b0;
            {e_re, e_clr, e_en, e_req, e_busy, e_done, e_to} = '0;
        end else if (m_active) begin
            m_t++;
            if (m_tfin == 0 && m_t >= m_n + 3 && m_t <= m_n + 2 + TMO && bus.mac_done === 1'b1)
                m_tfin = m_t + 1;
            else if (m_tfin == 0 && m_t == m_n + 2 + TMO) begin
                m_tfin = m_t + 1;
                m_to   = 1'b1;
            end
            e_clr  = (m_t == 1);
            e_re   = (m_n > 0) && (m_t >= 1) && (m_t <= m_n);
            e_ax   = (m_off + m_t - 1) % DEPTH;
            e_ay   = m_t - 1;
            e_en   = (m_n > 0) && (m_t >= 2) && (m_t <= m_n + 1);
            e_req  = (m_n > 0) && (m_t == m_n + 1);
            e_busy = (m_t >= 1) && (m_tfin == 0 || m_t < m_tfin);
            e_done = (m_t == m_tfin);
            e_to   = e_done && m_to;
            if (m_t == m_tfin) m_active = 1'b0;
        end else begin
            {e_re, e_clr, e_en, e_req, e_busy, e_done, e_to} = '0;
            if (bus.start === 1'b1) begin
                m_active = 1'b1;
                m_t      = 0;
                m_n      = int'(bus.length);
                m_off    = int'(bus.offset);
                m_to     = 1'b0;
                m_tfin   = (m_n == 0) ? 2 : 0;
            end
        end
    end

    // x RAM holds its own address, y RAM holds YV; one-cycle read latency.
    longint acc = 0, last_sum = 0;
    int rd_x = 0;
    int en_cnt = 0, done_cnt = 0, last_done_t = 0;
    logic last_to = 1'b0;

    always @(negedge ck) begin
        if (chk_en) begin
            chk("re",      64'(bus.re),      64'(e_re));
            chk("mac_clr", 64'(bus.mac_clr), 64'(e_clr));
            chk("mac_en",  64'(bus.mac_en),  64'(e_en));
            chk("mac_req", 64'(bus.mac_req), 64'(e_req));
            chk("busy",    64'(bus.busy),    64'(e_busy));
            chk("done",    64'(bus.done),    64'(e_done));
            chk("timeout", 64'(bus.timeout), 64'(e_to));
            if (e_re) begin
                chk("raddr_x", 64'(bus.raddr_x), 64'(e_ax));
                chk("raddr_y", 64'(bus.raddr_y), 64'(e_ay));
            end
            if (bus.mac_clr === 1'b1) acc = 0;
            if (bus.mac_en === 1'b1) begin
                acc += longint'(rd_x) * YV;
                en_cnt++;
                if (bus.mac_req === 1'b1) begin
                    last_sum = acc;
                    chk("mac_sum", 64'(acc), 64'(ref_sum(m_off, m_n)));
                end
            end
            if (bus.re === 1'b1) rd_x = int'(bus.raddr_x);
            if (bus.done === 1'b1) begin
                done_cnt++;
                last_done_t = m_t;
                last_to     = bus.timeout;
            end
        end
    end

    // MAC responder: answers mac_lat cycles after mac_req (never if <= 0),
    // plus optional stray mac_done pulses that the sequencer must ignore
    // outside its wait window.
    int mac_lat = 2;
    bit noise = 1'b0;
    int mac_cnt = 0;

    always @(negedge ck) begin
        bus.mac_done = 1'b0;
        if (reset) begin
            mac_cnt = 0;
        end else begin
            if (mac_cnt > 0) begin
                mac_cnt--;
                if (mac_cnt == 0) bus.mac_done = 1'b1;
            end
            if (bus.mac_req === 1'b1 && mac_lat > 0) mac_cnt = mac_lat;
            if (noise && $urandom_range(0, 15) == 0) bus.mac_done = 1'b1;
        end
    end

    // Called at a negedge with the sequencer idle; poke = edge index at which
    // a stray start is pulsed (0 = none).
    task automatic run(input int off, input int n, input int lat, input int poke);
        bit fin = 1'b0;
        mac_lat    = lat;
        bus.start  = 1'b1;
        bus.offset = A'(off);
        bus.length = (A+1)'(n);
        @(negedge ck);
        bus.offset = A'($urandom);
        bus.length = (A+1)'($urandom);
        for (int k = 1; k < 3000; k++) begin
            bus.start = (k == poke);
            @(negedge ck);
            if (!m_active) begin
                fin = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_bound: got no completion required done within 3000 cycles");
        end
        @(negedge ck);
    endtask

    int d_en, d_done;

    initial begin
        bus.start  = 1'b0;
        bus.offset = '0;
        bus.length = '0;
        repeat (3) @(negedge ck);
        chk_en = 1'b1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_re",   64'(bus.re),   64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        @(negedge ck);

        // Basic run
        d_en = en_cnt;
        run(0, 5, 2, 0);
        chk("basic_done_edge", 64'(last_done_t), 64'd10);
        chk("basic_timeout",   64'(last_to),     64'd0);
        chk("basic_en_cnt",    64'(en_cnt - d_en), 64'd5);

        // Wrap past the top of x RAM
        run(254, 4, 2, 0);
        chk("wrap_sum", 64'(last_sum), 64'd16711170);

        // Edge lengths
        d_en = en_cnt;
        run(17, 0, 2, 0);
        chk("n0_done_edge", 64'(last_done_t), 64'd2);
        chk("n0_en_cnt",    64'(en_cnt - d_en), 64'd0);
        d_en = en_cnt;
        run(99, 1, 2, 0);
        chk("n1_en_cnt",    64'(en_cnt - d_en), 64'd1);
        chk("n1_done_edge", 64'(last_done_t), 64'd6);
        d_en = en_cnt;
        run(3, 256, 2, 0);
        chk("n256_en_cnt", 64'(en_cnt - d_en), 64'd256);

        // MAC never answers
        run(40, 3, 0, 0);
        chk("tmo_done_edge", 64'(last_done_t), 64'd70);
        chk("tmo_flag",      64'(last_to),     64'd1);
        chk("tmo_busy_after", 64'(bus.busy),   64'd0);

        // Stray start while busy
        d_done = done_cnt;
        run(10, 5, 2, 3);
        chk("busy_start_dones", 64'(done_cnt - d_done), 64'd1);
        chk("busy_start_edge",  64'(last_done_t),       64'd10);

        // Reset in the middle of a run
        d_done = done_cnt;
        mac_lat    = 2;
        bus.start  = 1'b1;
        bus.offset = A'(7);
        bus.length = (A+1)'(5);
        @(negedge ck);
        bus.start = 1'b0;
        repeat (4) @(negedge ck);
        reset = 1'b1;
        @(negedge ck);
        chk("midrst_busy", 64'(bus.busy),    64'd0);
        chk("midrst_re",   64'(bus.re),      64'd0);
        chk("midrst_en",   64'(bus.mac_en),  64'd0);
        chk("midrst_clr",  64'(bus.mac_clr), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge ck);
        chk("midrst_dones", 64'(done_cnt - d_done), 64'd0);
        run(0, 5, 2, 0);
        chk("after_rst_done_edge", 64'(last_done_t), 64'd10);

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            int n;
            noise = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : DEPTH;
            else n = $urandom_range(1, 20);
            run($urandom_range(0, DEPTH - 1), n, $urandom_range(1, 80), $urandom_range(0, 30));
        end
        noise = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
